sram_rw_r_arbiter_gf180: RTL

Emulates a primary read/write port plus a secondary read-only port on top of a single-port GF180 SRAM array, such as a bank of 512x8 macros. The GF180 macro has only one port, so this block time-multiplexes the two ports onto it.
- Arbitrates each cycle and stalls the losing port via a busy flag.
- Merges identical concurrent reads into one access.
- Holds read data stable per port.
- Sits between the core/peripheral memory masters and the macro array, replacing the unsupported dual-port wrapper.

---
 rtl/sram_rw_r_arbiter_gf180_pkg.sv | 40 ++++
 rtl/sram_rw_r_grant_gf180.sv | 81 ++++++++
 rtl/sram_rw_r_arbiter_gf180.sv | 108 ++++++++++
 3 files changed

// File: rtl/sram_rw_r_arbiter_gf180_pkg.sv
// Shared definitions for the GF180 single-port SRAM read/write + read-only arbiter.
// Contents: word-size derivation, arbitration mode encodings, grant bundle type,
// last-grant state encoding and the byte-mask to active-low bit WEN expansion.
package sram_rw_r_arbiter_gf180_pkg;

    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned MAX_BYTE_COUNT = 8;
    localparam int unsigned MAX_WORD_SIZE  = BITS_PER_BYTE * MAX_BYTE_COUNT;

    localparam int unsigned ARB_PRIORITY    = 0;
    localparam int unsigned ARB_ROUND_ROBIN = 1;

    // Which port was granted alone most recently (round-robin memory).
    typedef enum logic {
        LAST_PRIMARY   = 1'b0,
        LAST_SECONDARY = 1'b1
    } last_grant_t;

    // Per-cycle decision of the grant unit.
    typedef struct packed {
        logic primary;
        logic secondary;
        logic merge;
    } grant_t;

    function automatic int unsigned word_size(input int unsigned byte_count);
        return BITS_PER_BYTE * byte_count;
    endfunction

    // Byte enables (active-high) to macro bit write enables (active-low).
    function automatic logic [MAX_WORD_SIZE-1:0] expand_wen(input logic [MAX_BYTE_COUNT-1:0] mask);
        logic [MAX_WORD_SIZE-1:0] wen;
        wen = '1;
        for (int unsigned k = 0; k < MAX_BYTE_COUNT; k++) begin
            wen[k*BITS_PER_BYTE +: BITS_PER_BYTE] = {BITS_PER_BYTE{~mask[k]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/sram_rw_r_grant_gf180.sv
// Grant unit: decides per cycle which of the two ports owns the macro.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   primary_req         primary request (already gated by reset)
//   secondary_req       secondary read request (already gated by reset)
//   primary_write       primary request is a write
//   address_equal       primary and secondary addresses match
//   grant_c             combinational grants + merge flag
// State: wait_count (mode 0 starvation counter), last_grant (mode 1 alternation).
module sram_rw_r_grant_gf180
    import sram_rw_r_arbiter_gf180_pkg::*;
#(
    parameter int unsigned ARBITRATION_MODE   = ARB_PRIORITY,
    parameter int unsigned SECONDARY_MAX_WAIT = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   primary_req,
    input  logic   secondary_req,
    input  logic   primary_write,
    input  logic   address_equal,
    output grant_t grant_c
);

    localparam int unsigned WAIT_W = $clog2(SECONDARY_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(SECONDARY_MAX_WAIT);

    logic [WAIT_W-1:0] wait_count;
    logic [WAIT_W-1:0] wait_count_next;
    last_grant_t       last_grant;
    last_grant_t       last_grant_next;
    logic              merge;
    logic              contention;
    logic              secondary_wins;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_count <= '0;
            last_grant <= LAST_SECONDARY;
        end else begin
            wait_count <= wait_count_next;
            last_grant <= last_grant_next;
        end
    end

    // Grant decision and next state.
    always_comb begin
        grant_c         = '0;
        wait_count_next = '0;
        last_grant_next = last_grant;
        secondary_wins  = 1'b0;

        // Identical concurrent reads share one access.
        merge      = primary_req && secondary_req && !primary_write && address_equal;
        contention = primary_req && secondary_req && !merge;

        if (ARBITRATION_MODE == ARB_ROUND_ROBIN) begin
            secondary_wins = (last_grant == LAST_PRIMARY);
        end else begin
            secondary_wins = (wait_count == WAIT_LIMIT);
        end

        grant_c.merge     = merge;
        grant_c.primary   = primary_req && !(contention && secondary_wins);
        grant_c.secondary = secondary_req && !(contention && !secondary_wins);

        // Counter clears on any cycle the secondary is granted or idle.
        if (ARBITRATION_MODE == ARB_PRIORITY && secondary_req && !grant_c.secondary) begin
            wait_count_next = (wait_count == WAIT_LIMIT) ? wait_count : wait_count + 1'b1;
        end

        // Merged grants leave the alternation untouched.
        if (grant_c.primary && !grant_c.secondary) begin
            last_grant_next = LAST_PRIMARY;
        end else if (grant_c.secondary && !grant_c.primary) begin
            last_grant_next = LAST_SECONDARY;
        end
    end

endmodule

// File: rtl/sram_rw_r_arbiter_gf180.sv
// Emulates a read/write primary port and a read-only secondary port on one
// single-port GF180 SRAM macro array by per-cycle arbitration.
// Ports:
//   clk, rst                      clock, async active-low reset
//   primary*                      R/W master: select, write enable, byte mask,
//                                 address, write data, read data, busy
//   secondary*                    read-only master: select, address, read data, busy
//   sram*                         macro interface: CEN/GWEN/WEN active-low,
//                                 address, write data, read data (1-cycle latency)
// Busy and sram* outputs are combinational from the requests and arbiter state;
// read data is the macro output in the cycle after acceptance, then held.
module sram_rw_r_arbiter_gf180
    import sram_rw_r_arbiter_gf180_pkg::*;
#(
    parameter int unsigned BYTE_COUNT         = 4,
    parameter int unsigned ADDRESS_SIZE       = 9,
    parameter int unsigned ARBITRATION_MODE   = ARB_PRIORITY,
    parameter int unsigned SECONDARY_MAX_WAIT = 3,
    localparam int unsigned WORD_SIZE         = word_size(BYTE_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    primarySelect,
    input  logic                    primaryWriteEnable,
    input  logic [BYTE_COUNT-1:0]   primaryWriteMask,
    input  logic [ADDRESS_SIZE-1:0] primaryAddress,
    input  logic [WORD_SIZE-1:0]    primaryDataWrite,
    output logic [WORD_SIZE-1:0]    primaryDataRead,
    output logic                    primaryBusy,
    input  logic                    secondarySelect,
    input  logic [ADDRESS_SIZE-1:0] secondaryAddress,
    output logic [WORD_SIZE-1:0]    secondaryDataRead,
    output logic                    secondaryBusy,
    output logic                    sramCEN,
    output logic                    sramGWEN,
    output logic [WORD_SIZE-1:0]    sramWEN,
    output logic [ADDRESS_SIZE-1:0] sramAddress,
    output logic [WORD_SIZE-1:0]    sramDataWrite,
    input  logic [WORD_SIZE-1:0]    sramDataRead
);

    grant_t                  grant;
    logic                    primary_req;
    logic                    secondary_req;
    logic                    primary_write_grant;
    logic [MAX_BYTE_COUNT-1:0] mask_ext;
    logic [MAX_WORD_SIZE-1:0]  wen_full;
    logic                    primary_pending;
    logic                    secondary_pending;
    logic [WORD_SIZE-1:0]    primary_hold;
    logic [WORD_SIZE-1:0]    secondary_hold;

    // No grants while reset is asserted, so Busy simply mirrors Select.
    assign primary_req   = primarySelect && rst;
    assign secondary_req = secondarySelect && rst;

    sram_rw_r_grant_gf180 #(
        .ARBITRATION_MODE   (ARBITRATION_MODE),
        .SECONDARY_MAX_WAIT (SECONDARY_MAX_WAIT)
    ) u_grant (
        .clk           (clk),
        .rst_n         (rst),
        .primary_req   (primary_req),
        .secondary_req (secondary_req),
        .primary_write (primaryWriteEnable),
        .address_equal (primaryAddress == secondaryAddress),
        .grant_c       (grant)
    );

    assign primaryBusy   = primarySelect && !grant.primary;
    assign secondaryBusy = secondarySelect && !grant.secondary;

    // Macro access mux.
    assign primary_write_grant = grant.primary && primaryWriteEnable;
    assign mask_ext            = MAX_BYTE_COUNT'(primaryWriteMask);
    assign wen_full            = expand_wen(mask_ext);

    assign sramCEN       = !(grant.primary || grant.secondary);
    assign sramGWEN      = !primary_write_grant;
    assign sramWEN       = primary_write_grant ? wen_full[WORD_SIZE-1:0] : '1;
    // Secondary address only when it owns the slot alone; a merge shares the primary address.
    assign sramAddress   = (grant.secondary && !grant.merge) ? secondaryAddress : primaryAddress;
    assign sramDataWrite = primaryDataWrite;

    // Read pipeline flags and per-port hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primary_pending   <= 1'b0;
            secondary_pending <= 1'b0;
            primary_hold      <= '0;
            secondary_hold    <= '0;
        end else begin
            primary_pending   <= grant.primary && !primaryWriteEnable;
            secondary_pending <= grant.secondary;
            if (primary_pending) begin
                primary_hold <= sramDataRead;
            end
            if (secondary_pending) begin
                secondary_hold <= sramDataRead;
            end
        end
    end

    // Macro data passes straight through in the cycle after acceptance.
    assign primaryDataRead   = primary_pending   ? sramDataRead : primary_hold;
    assign secondaryDataRead = secondary_pending ? sramDataRead : secondary_hold;

endmodule
